// File: rtl/dout_writer.sv
// dout_writer: serialises eight 24-bit channel samples onto four data lanes.
// Each lane carries two 32-bit words per frame (sample MSB first, then the
// status byte). A frame is a DRDY strobe of one dclk period, followed by 64
// dclk periods of data, followed by a single-cycle done pulse.
//
// Request semantics: tick_i is a one-cycle start request. It is accepted
// only while the FSM is IDLE (busy_o=0), and the samples are captured on that
// same edge. A tick_i seen while busy_o=1 (including the DONE cycle) is
// dropped and sets the sticky overrun_o flag.
module dout_writer #(
   parameter int unsigned CLK_DIV     = 4,
   parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        tick_i,
   input  logic [23:0] ch1_i,
   input  logic [23:0] ch2_i,
   input  logic [23:0] ch3_i,
   input  logic [23:0] ch4_i,
   input  logic [23:0] ch5_i,
   input  logic [23:0] ch6_i,
   input  logic [23:0] ch7_i,
   input  logic [23:0] ch8_i,
   output logic        drdy_o,
   output logic        dclk_o,
   output logic        dout0_o,
   output logic        dout1_o,
   output logic        dout2_o,
   output logic        dout3_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        overrun_o,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRDY  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Reload values: cycles per dclk half-period and per DRDY phase, minus one.
   localparam logic [8:0] HALF_M1 = 9'(CLK_DIV - 1);
   localparam logic [8:0] DRDY_M1 = 9'(2 * CLK_DIV - 1);

   state_t            state;
   logic [8:0]        div_cnt;     // cycles left in the current phase
   logic [5:0]        period_cnt;  // dclk periods already completed in SHIFT
   logic [3:0][63:0]  sh;          // per-lane shadow / shift registers
   logic [3:0]        lanes_q;
   logic [3:0][63:0]  stream;      // per-lane 64-bit word built from the inputs
   logic [3:0]        top_bits;
   logic [3:0]        next_bits;

   // Assemble each lane's frame image: channel k+1 word, then channel k+5 word.
   always_comb begin
      stream[0] = {ch1_i, STATUS_BYTE, ch5_i, STATUS_BYTE};
      stream[1] = {ch2_i, STATUS_BYTE, ch6_i, STATUS_BYTE};
      stream[2] = {ch3_i, STATUS_BYTE, ch7_i, STATUS_BYTE};
      stream[3] = {ch4_i, STATUS_BYTE, ch8_i, STATUS_BYTE};
      for (int k = 0; k < 4; k++) begin
         top_bits[k]  = stream[k][63];
         next_bits[k] = sh[k][62];
      end
   end

   // Frame FSM with divider, bit counter, shadow registers and registered outputs.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state      <= IDLE;
         div_cnt    <= '0;
         period_cnt <= '0;
         sh         <= '0;
         lanes_q    <= '0;
         drdy_o     <= 1'b0;
         dclk_o     <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         overrun_o  <= 1'b0;
      end else begin
         if (tick_i && (state != IDLE)) begin
            overrun_o <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               drdy_o  <= 1'b0;
               dclk_o  <= 1'b0;
               done_o  <= 1'b0;
               lanes_q <= '0;
               if (tick_i) begin
                  state      <= DRDY;
                  sh         <= stream;
                  lanes_q    <= top_bits;
                  drdy_o     <= 1'b1;
                  busy_o     <= 1'b1;
                  div_cnt    <= DRDY_M1;
                  period_cnt <= '0;
               end
            end
            DRDY: begin
               // Bit 63 is already on the lanes; it stays through the first low phase.
               if (div_cnt == '0) begin
                  state   <= SHIFT;
                  drdy_o  <= 1'b0;
                  div_cnt <= HALF_M1;
               end else begin
                  div_cnt <= div_cnt - 9'd1;
               end
            end
            SHIFT: begin
               if (div_cnt != '0) begin
                  div_cnt <= div_cnt - 9'd1;
               end else if (!dclk_o) begin
                  dclk_o  <= 1'b1;
                  div_cnt <= HALF_M1;
               end else if (period_cnt == 6'd63) begin
                  state   <= DONE;
                  dclk_o  <= 1'b0;
                  lanes_q <= '0;
                  done_o  <= 1'b1;
               end else begin
                  // Falling edge of dclk: the only place lane data advances.
                  dclk_o     <= 1'b0;
                  div_cnt    <= HALF_M1;
                  period_cnt <= period_cnt + 6'd1;
                  lanes_q    <= next_bits;
                  for (int k = 0; k < 4; k++) begin
                     sh[k] <= {sh[k][62:0], 1'b0};
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
               busy_o <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign dout0_o = lanes_q[0];
   assign dout1_o = lanes_q[1];
   assign dout2_o = lanes_q[2];
   assign dout3_o = lanes_q[3];
   assign state_o = state;

endmodule

// File: tb/tb_dout_writer.sv
// tb_dout_writer: two instances (CLK_DIV=4/status 00 and CLK_DIV=1/status A5)
// sharing channel inputs and reset. Frames are captured on dclk rising edges
// and compared with lane words built directly from the channel values.
module tb_dout_writer;

   // ---------------- clock / reset ----------------
   logic clk_i    = 1'b0;
   logic reset_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------- stimulus / DUTs ----------------
   logic        tick_x = 1'b0;
   int          sel    = 0;
   logic [23:0] ch_v [8];

   logic tick_a, drdy_a, dclk_a, d0_a, d1_a, d2_a, d3_a, busy_a, done_a, ovr_a;
   logic tick_b, drdy_b, dclk_b, d0_b, d1_b, d2_b, d3_b, busy_b, done_b, ovr_b;
   logic [1:0] state_a, state_b;

   assign tick_a = tick_x && (sel == 0);
   assign tick_b = tick_x && (sel == 1);

   dout_writer #(.CLK_DIV(4), .STATUS_BYTE(8'h00)) u_a (
      .clk_i(clk_i), .reset_ni(reset_ni), .tick_i(tick_a),
      .ch1_i(ch_v[0]), .ch2_i(ch_v[1]), .ch3_i(ch_v[2]), .ch4_i(ch_v[3]),
      .ch5_i(ch_v[4]), .ch6_i(ch_v[5]), .ch7_i(ch_v[6]), .ch8_i(ch_v[7]),
      .drdy_o(drdy_a), .dclk_o(dclk_a),
      .dout0_o(d0_a), .dout1_o(d1_a), .dout2_o(d2_a), .dout3_o(d3_a),
      .busy_o(busy_a), .done_o(done_a), .overrun_o(ovr_a), .state_o(state_a)
   );

   dout_writer #(.CLK_DIV(1), .STATUS_BYTE(8'hA5)) u_b (
      .clk_i(clk_i), .reset_ni(reset_ni), .tick_i(tick_b),
      .ch1_i(ch_v[0]), .ch2_i(ch_v[1]), .ch3_i(ch_v[2]), .ch4_i(ch_v[3]),
      .ch5_i(ch_v[4]), .ch6_i(ch_v[5]), .ch7_i(ch_v[6]), .ch8_i(ch_v[7]),
      .drdy_o(drdy_b), .dclk_o(dclk_b),
      .dout0_o(d0_b), .dout1_o(d1_b), .dout2_o(d2_b), .dout3_o(d3_b),
      .busy_o(busy_b), .done_o(done_b), .overrun_o(ovr_b), .state_o(state_b)
   );

   // Outputs of the currently selected instance.
   logic       m_drdy, m_dclk, m_busy, m_done, m_ovr;
   logic [3:0] m_lanes;
   assign m_drdy  = (sel == 0) ? drdy_a : drdy_b;
   assign m_dclk  = (sel == 0) ? dclk_a : dclk_b;
   assign m_busy  = (sel == 0) ? busy_a : busy_b;
   assign m_done  = (sel == 0) ? done_a : done_b;
   assign m_ovr   = (sel == 0) ? ovr_a  : ovr_b;
   assign m_lanes = (sel == 0) ? {d3_a, d2_a, d1_a, d0_a} : {d3_b, d2_b, d1_b, d0_b};

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_q [$];
   logic [63:0] cap [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference deserializer: pull one channel back out of a lane word, sign-extended.
   function automatic logic [31:0] deser(input logic [63:0] w, input bit first);
      logic [23:0] s;
      s = first ? w[63:40] : w[31:8];
      return {{8{s[23]}}, s};
   endfunction

   // ---------------- driver: one frame, captured and checked ----------------
   task automatic run_frame(input int which, input int tick2_at, input bit tick_in_done,
                            input logic exp_ovr);
      int          d, cyc, lat, nbits, drdy_n, proto_err, idle_cnt;
      logic [7:0]  st;
      logic        prev_dclk, first_busy, first_drdy;
      logic [3:0]  prev_lanes, first_lanes, exp_top;
      logic [4:0]  done_out;
      bit          got_done;
      sel = which;
      d   = (which == 0) ? 4 : 1;
      st  = (which == 0) ? 8'h00 : 8'hA5;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({ch_v[k], st, ch_v[k+4], st});
         exp_top[k] = ch_v[k][23];
         cap[k]     = '0;
      end
      nbits = 0; drdy_n = 0; proto_err = 0; got_done = 0; lat = 0; done_out = '1;
      tick_x = 1'b1;
      @(negedge clk_i);
      tick_x      = 1'b0;
      cyc         = 1;
      first_busy  = m_busy;
      first_drdy  = m_drdy;
      first_lanes = m_lanes;
      prev_dclk   = 1'b0;
      prev_lanes  = m_lanes;
      while (!got_done && cyc < 4000) begin
         if (m_drdy) begin
            drdy_n++;
            if (m_dclk) proto_err++;
         end
         if (m_dclk && !prev_dclk) begin
            for (int k = 0; k < 4; k++) cap[k] = {cap[k][62:0], m_lanes[k]};
            nbits++;
         end
         if ((m_lanes !== prev_lanes) && !(prev_dclk && !m_dclk)) proto_err++;
         if (m_done) begin
            got_done = 1;
            lat      = cyc;
            done_out = {m_dclk, m_lanes};
         end else begin
            prev_dclk  = m_dclk;
            prev_lanes = m_lanes;
            if (cyc == 50) begin
               for (int k = 0; k < 8; k++) ch_v[k] = 24'($urandom);
            end
            tick_x = (tick2_at != 0) && (cyc == tick2_at);
            @(negedge clk_i);
            cyc++;
         end
      end
      tick_x = 1'b0;
      check("done_seen",  64'(got_done), 64'd1);
      check("frame_len",  64'(lat), 64'(2 * d * 65 + 1));
      check("busy_rise",  64'(first_busy), 64'd1);
      check("drdy_first", 64'(first_drdy), 64'd1);
      check("lanes_bit63", 64'(first_lanes), 64'(exp_top));
      check("drdy_len",   64'(drdy_n), 64'(2 * d));
      check("dclk_rises", 64'(nbits), 64'd64);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("lane%0d", k), cap[k], exp_q.pop_front());
      end
      check("lane_timing", 64'(proto_err), 64'd0);
      check("done_dclk_lanes", 64'(done_out), 64'd0);
      check("overrun", 64'(m_ovr), 64'(exp_ovr));
      if (tick_in_done) begin
         tick_x = 1'b1;             // lands on the DONE cycle
         @(negedge clk_i);
         check("done_one_cycle", 64'({m_busy, m_done}), 64'd0);
         check("overrun_done_tick", 64'(m_ovr), 64'd1);
         @(negedge clk_i);          // tick held through the first IDLE cycle
         tick_x = 1'b0;
         check("busy_after_idle_tick", 64'(m_busy), 64'd1);
         cyc = 0;
         while (!m_done && cyc < 4000) begin
            @(negedge clk_i);
            cyc++;
         end
         check("refire_done", 64'(m_done), 64'd1);
         @(negedge clk_i);
      end else begin
         @(negedge clk_i);
         check("done_one_cycle", 64'({m_busy, m_done}), 64'd0);
         idle_cnt = 0;
         repeat (20) begin
            @(negedge clk_i);
            if (m_busy || m_done) idle_cnt++;
         end
         check("stays_idle", 64'(idle_cnt), 64'd0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      reset_ni = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int               which;
      logic [7:0][23:0] ch;
      logic [63:0]      exp_lane0;
   } vec_t;

   vec_t vt [4];

   // Watchdog so a stuck run still ends with a report.
   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int nb, cyc, bad;
      logic prev;
      for (int k = 0; k < 8; k++) ch_v[k] = '0;

      vt[0].which = 0; vt[0].ch = '0; vt[0].ch[0] = 24'h800001;
      vt[0].exp_lane0 = 64'h80000100_00000000;
      vt[1].which = 0;
      for (int j = 0; j < 8; j++) vt[1].ch[j] = 24'(24'h111111 * (j + 1));
      vt[1].exp_lane0 = 64'h11111100_55555500;
      vt[2].which = 1; vt[2].ch = '0; vt[2].ch[4] = 24'hFFFFFF;
      vt[2].exp_lane0 = 64'h000000A5_FFFFFFA5;
      vt[3].which = 1; vt[3].ch = '0; vt[3].ch[0] = 24'h7FFFFE; vt[3].ch[4] = 24'h000001;
      vt[3].exp_lane0 = 64'h7FFFFEA5_000001A5;

      // Reset state of both instances.
      repeat (3) @(negedge clk_i);
      check("reset_outs_a", 64'({drdy_a, dclk_a, d3_a, d2_a, d1_a, d0_a, busy_a, done_a, ovr_a, state_a}), 64'd0);
      check("reset_outs_b", 64'({drdy_b, dclk_b, d3_b, d2_b, d1_b, d0_b, busy_b, done_b, ovr_b, state_b}), 64'd0);

      // Release reset and tick on the very first edge afterwards.
      @(negedge clk_i);
      reset_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 8; j++) ch_v[j] = vt[i].ch[j];
         run_frame(vt[i].which, 0, 1'b0, 1'b0);
         check($sformatf("vec%0d_dout0", i), cap[0], vt[i].exp_lane0);
         if (i == 1) begin
            check("deser_ch1", 64'(deser(cap[0], 1'b1)), 64'h00111111);
            check("deser_ch8", 64'(deser(cap[3], 1'b0)), 64'hFF888888);
         end
      end

      // Randomized frames on either instance.
      repeat (6) begin
         for (int k = 0; k < 8; k++) ch_v[k] = 24'($urandom);
         run_frame(int'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
      end

      // Second tick mid-frame: ignored, overrun set, content unchanged.
      for (int k = 0; k < 8; k++) ch_v[k] = 24'($urandom);
      run_frame(0, 190, 1'b0, 1'b1);

      // Tick in the DONE cycle rejected, tick one cycle later accepted.
      do_reset();
      for (int k = 0; k < 8; k++) ch_v[k] = 24'($urandom);
      run_frame(1, 0, 1'b1, 1'b0);

      // Reset pulse mid-SHIFT (bit 40 on the lanes) aborts the frame at once.
      do_reset();
      @(negedge clk_i);
      sel = 0;
      for (int k = 0; k < 8; k++) ch_v[k] = 24'($urandom);
      tick_x = 1'b1;
      @(negedge clk_i);
      tick_x = 1'b0;
      nb = 0; cyc = 0; prev = 1'b0;
      while (nb < 24 && cyc < 2000) begin
         if (dclk_a && !prev) nb++;
         prev = dclk_a;
         if (nb < 24) begin
            @(negedge clk_i);
            cyc++;
         end
      end
      check("reach_bit40", 64'(nb), 64'd24);
      #2 reset_ni = 1'b0;
      #1;
      check("async_abort_a", 64'({drdy_a, dclk_a, d3_a, d2_a, d1_a, d0_a, busy_a, done_a, ovr_a, state_a}), 64'd0);
      repeat (3) @(negedge clk_i);
      reset_ni = 1'b1;
      bad = 0;
      repeat (600) begin
         @(negedge clk_i);
         if (done_a || busy_a) bad++;
      end
      check("no_done_after_abort", 64'(bad), 64'd0);
      for (int k = 0; k < 8; k++) ch_v[k] = 24'($urandom);
      run_frame(0, 0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dout_writer.md
DOUT_WRITER -- requirements
Module: dout_writer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the number of clk_i cycles per dclk_o half-period; the legal range is 1..255.
REQ-002 The block SHALL have parameter STATUS_BYTE, default 8'h00, giving the 8 bits appended after each 24-bit sample.
REQ-003 Port clk_i: input, 1 bit, the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset_ni: input, 1 bit, asynchronous, active-low reset.
REQ-005 Port tick_i: input, 1 bit, a one-cycle frame start request.
REQ-006 Ports ch1_i..ch8_i: input, 24 bits each, signed two's-complement channel samples.
REQ-007 Port drdy_o: output, 1 bit, data-ready strobe marking the start of a frame.
REQ-008 Port dclk_o: output, 1 bit, serial bit clock.
REQ-009 Ports dout0_o..dout3_o: output, 1 bit each, the four serial data lanes.
REQ-010 Port busy_o: output, 1 bit, high while a frame is in progress.
REQ-011 Port done_o: output, 1 bit, a one-cycle pulse at the end of a frame.
REQ-012 Port overrun_o: output, 1 bit, sticky flag for a tick_i received while busy.

Function
REQ-013 Lane k (k = 0..3) SHALL carry channel k+1 first, then channel k+5.
REQ-014 Each channel word SHALL be 32 bits: the 24-bit sample MSB first, followed by STATUS_BYTE MSB first; each lane therefore carries 64 bits per frame.
REQ-015 FSM states: IDLE, DRDY, SHIFT, DONE.
REQ-016 IDLE: on tick_i, all eight samples SHALL be latched into shadow registers in that same cycle, the FSM SHALL go to DRDY, and busy_o SHALL rise on the next cycle.
REQ-017 Samples SHALL be latched only on an accepted tick_i; input changes during a frame SHALL NOT affect the transmitted bits.
REQ-018 DRDY: lasts 2*CLK_DIV cycles with drdy_o=1 and dclk_o=0; each lane drives bit 63 of its 64-bit stream.
REQ-019 SHIFT: lasts 64 dclk periods, each being CLK_DIV cycles with dclk_o=0 followed by CLK_DIV cycles with dclk_o=1; drdy_o=0.
REQ-020 Lane data SHALL change only on the cycle where dclk_o falls (high to low) and SHALL be stable throughout each high phase.
REQ-021 Bit n SHALL be valid during dclk period 63-n, for n = 63 down to 0.
REQ-022 After the 64th high phase the FSM SHALL enter DONE: dclk_o=0, lanes=0, done_o=1 for exactly one cycle, then return to IDLE.
REQ-023 busy_o SHALL be 1 in DRDY, SHIFT and DONE, and 0 in IDLE.
REQ-024 Frame length from accepted tick_i to done_o SHALL be 2*CLK_DIV*65+1 cycles.
REQ-025 tick_i while busy_o=1 SHALL be ignored and SHALL set overrun_o=1, which stays set until reset.
REQ-026 tick_i in the DONE cycle SHALL be treated as an overrun.
REQ-027 tick_i in the first IDLE cycle after DONE SHALL be accepted.
REQ-028 In IDLE, outputs SHALL be: drdy_o=0, dclk_o=0, lanes=0, done_o=0.
REQ-029 The dclk divider counter SHALL reload exactly at each phase boundary, with no cumulative drift.
REQ-030 With CLK_DIV=1, dclk_o SHALL toggle every clk_i cycle.

Reset
REQ-031 While reset_ni=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counters and shadow registers SHALL be cleared.
REQ-032 A reset asserted mid-frame SHALL abort the frame immediately (asynchronously); no done_o SHALL follow.
REQ-033 After reset_ni rises, the block SHALL accept a tick_i from the first rising clk_i edge.

Verification
REQ-034 CLK_DIV=4, ch1=24'h800001, others=0, tick_i -> on dout0_o, sample on dclk_o rising edges: 1000_0000_0000_0000_0000_0001 then 8 zeros, then 32 zeros; done_o occurs 521 cycles after tick_i.
REQ-035 ch1..ch8=24'h111111..24'h888888 looped into the existing ADC deserializer -> its ch1..ch8 outputs equal the inputs sign-extended (24'h888888 -> 32'hFF888888).
REQ-036 tick_i at cycle 10 and again at cycle 200 -> a single frame, overrun_o=1, and the frame content is unchanged.
REQ-037 reset_ni pulsed low during SHIFT bit 40 -> all outputs 0 within the same cycle; no done_o; a new tick_i afterwards yields a complete correct frame.
REQ-038 CLK_DIV=1, ch5=24'hFFFFFF, STATUS_BYTE=8'hA5 -> dclk_o toggles every cycle; dout0_o bits 31..0 = FFFFFF then A5.
REQ-039 tick_i in the DONE cycle -> rejected with overrun_o=1; tick_i one cycle later -> accepted, and busy_o rises.
